r2sdf_stage_ctrl: RTL and testbench

- Sequencer for one radix-2 single-path delay-feedback (R2SDF) FFT stage.
- Owns a DEPTH-entry feedback delay line and a frame counter, and time-multiplexes the stage's scaled add/sub butterfly.
- Emits stage output with a frame index so the downstream twiddle multiplier can address its ROM.
- Adds a flush/drain handshake so the last frame's difference half can leave the stage without a following frame.

---
 rtl/r2sdf_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_r2sdf_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: feedback
// delay line, frame counter, time-shared scaled butterfly and flush/drain.
module r2sdf_stage_ctrl #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  di_en,
    input  logic [WIDTH-1:0]      di_re,
    input  logic [WIDTH-1:0]      di_im,
    output logic                  di_ready,
    input  logic                  flush,
    output logic                  do_en,
    output logic [WIDTH-1:0]      do_re,
    output logic [WIDTH-1:0]      do_im,
    output logic [LOG2_DEPTH:0]   do_idx,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] CNT_HALF_LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FRAME_LAST = CW'(2 * DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_BFLY   = 2'd1,
        ST_FILL_P = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [WIDTH-1:0]      dl_re_q [DEPTH];
    logic [WIDTH-1:0]      dl_im_q [DEPTH];
    logic                  do_en_q;
    logic [WIDTH-1:0]      do_re_q;
    logic [WIDTH-1:0]      do_im_q;
    logic [LOG2_DEPTH:0]   do_idx_q;

    logic                  adv;
    logic                  out_vld_d;
    logic [WIDTH-1:0]      dl_in_re_d, dl_in_im_d;
    logic [WIDTH-1:0]      out_re_d, out_im_d;
    logic [LOG2_DEPTH:0]   out_idx_d;
    logic signed [WIDTH:0] sum_re, sum_im, dif_re, dif_im;
    logic [WIDTH-1:0]      head_re, head_im;
    logic [LOG2_DEPTH-1:0] k;

    // Input handshake: a sample transfers on a clock edge where di_en and
    // di_ready are both high; di_en while di_ready is low is dropped.
    assign di_ready    = (state_q != ST_DRAIN);
    assign busy        = (state_q != ST_FILL);
    assign dbg_state_o = state_q;
    assign do_en       = do_en_q;
    assign do_re       = do_re_q;
    assign do_im       = do_im_q;
    assign do_idx      = do_idx_q;

    assign head_re = dl_re_q[DEPTH-1];
    assign head_im = dl_im_q[DEPTH-1];
    assign k       = cnt_q[LOG2_DEPTH-1:0];

    always_comb begin
        // One extra bit of headroom so the halved result never wraps.
        sum_re = {head_re[WIDTH-1], head_re} + {di_re[WIDTH-1], di_re};
        sum_im = {head_im[WIDTH-1], head_im} + {di_im[WIDTH-1], di_im};
        dif_re = {di_re[WIDTH-1], di_re} - {head_re[WIDTH-1], head_re};
        dif_im = {di_im[WIDTH-1], di_im} - {head_im[WIDTH-1], head_im};

        adv        = (state_q == ST_DRAIN) | (di_en & di_ready);
        dl_in_re_d = di_re;
        dl_in_im_d = di_im;
        out_re_d   = head_re;
        out_im_d   = head_im;
        out_idx_d  = {1'b1, k};
        out_vld_d  = 1'b1;
        case (state_q)
            ST_FILL: out_vld_d = 1'b0;
            ST_BFLY: begin
                dl_in_re_d = WIDTH'(dif_re >>> 1);
                dl_in_im_d = WIDTH'(dif_im >>> 1);
                out_re_d   = WIDTH'(sum_re >>> 1);
                out_im_d   = WIDTH'(sum_im >>> 1);
                out_idx_d  = {1'b0, k};
            end
            ST_DRAIN: begin
                dl_in_re_d = '0;
                dl_in_im_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FILL;
            cnt_q    <= '0;
            do_en_q  <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
            do_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else begin
            do_en_q <= adv & out_vld_d;
            if (adv & out_vld_d) begin
                do_re_q  <= out_re_d;
                do_im_q  <= out_im_d;
                do_idx_q <= out_idx_d;
            end
            if (adv) begin
                cnt_q <= cnt_q + CW'(1);
                for (int i = DEPTH - 1; i > 0; i--) begin
                    dl_re_q[i] <= dl_re_q[i-1];
                    dl_im_q[i] <= dl_im_q[i-1];
                end
                dl_re_q[0] <= dl_in_re_d;
                dl_im_q[0] <= dl_in_im_d;
            end
            case (state_q)
                ST_FILL:
                    if (adv && cnt_q == CNT_HALF_LAST) state_q <= ST_BFLY;
                ST_BFLY:
                    if (adv && cnt_q == CNT_FRAME_LAST) state_q <= ST_FILL_P;
                ST_FILL_P:
                    if (adv && cnt_q == CNT_HALF_LAST) state_q <= ST_BFLY;
                    else if (cnt_q == '0 && flush && !di_en) state_q <= ST_DRAIN;
                ST_DRAIN:
                    // Drain always starts at cnt=0, so DEPTH cycles end here.
                    if (cnt_q == CNT_HALF_LAST) begin
                        state_q <= ST_FILL;
                        cnt_q   <= '0;
                    end
                default: state_q <= ST_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// Bench for r2sdf_stage_ctrl: frame-level reference model (sample buffer plus
// queue of pending differences) checked cycle by cycle with directed steps.
module tb_r2sdf_stage_ctrl;
  localparam int W = 16;
  localparam int L = 2;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         di_en;
  logic [W-1:0] di_re, di_im;
  logic         di_ready;
  logic         flush;
  logic         do_en;
  logic [W-1:0] do_re, do_im;
  logic [L:0]   do_idx;
  logic         busy;
  logic [1:0]   dbg_state;

  r2sdf_stage_ctrl #(.WIDTH(W), .LOG2_DEPTH(L)) dut (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .di_ready(di_ready), .flush(flush), .do_en(do_en), .do_re(do_re),
    .do_im(do_im), .do_idx(do_idx), .busy(busy), .dbg_state_o(dbg_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // reference model
  int p;
  int drain_left;
  int buf_re[D];
  int buf_im[D];
  int pend_re[$];
  int pend_im[$];
  logic [W-1:0] last_re, last_im;
  logic [L:0]   last_idx;

  // observation log for directed checks
  int obs_re[$];
  int obs_idx[$];
  int ready_low;

  int basic_re[8] = '{2, 3, 4, 5, 2, 2, 2, 2};
  int ext_re[8]   = '{32767, -1, -1, -1, 0, -32768, 32767, -1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    p = 0;
    drain_left = 0;
    pend_re.delete();
    pend_im.delete();
    for (int i = 0; i < D; i++) begin
      buf_re[i] = 0;
      buf_im[i] = 0;
    end
    last_re = '0;
    last_im = '0;
    last_idx = '0;
  endtask

  task automatic log_clear();
    obs_re.delete();
    obs_idx.delete();
    ready_low = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic step(input logic en, input int re, input int im, input logic fl);
    int o_re, o_im, o_idx, kk;
    logic o_v;
    di_en = en;
    di_re = W'(re);
    di_im = W'(im);
    flush = fl;
    o_v = 1'b0;
    o_re = 0;
    o_im = 0;
    o_idx = 0;
    if (drain_left > 0) begin
      o_re = pend_re.pop_front();
      o_im = pend_im.pop_front();
      o_idx = D + (D - drain_left);
      o_v = 1'b1;
      drain_left--;
    end else if (en) begin
      if (p < D) begin
        buf_re[p] = re;
        buf_im[p] = im;
        if (pend_re.size() > 0) begin
          o_re = pend_re.pop_front();
          o_im = pend_im.pop_front();
          o_idx = D + p;
          o_v = 1'b1;
        end
      end else begin
        kk = p - D;
        o_re = (buf_re[kk] + re) >>> 1;
        o_im = (buf_im[kk] + im) >>> 1;
        pend_re.push_back((re - buf_re[kk]) >>> 1);
        pend_im.push_back((im - buf_im[kk]) >>> 1);
        o_idx = kk;
        o_v = 1'b1;
      end
      p = (p + 1) % (2 * D);
    end else if (p == 0 && pend_re.size() > 0 && fl) begin
      drain_left = D;
    end
    @(posedge clock);
    #1;
    if (o_v) begin
      last_re = W'(o_re);
      last_im = W'(o_im);
      last_idx = (L + 1)'(o_idx);
    end
    chk("do_en", do_en, o_v);
    chk("do_re", do_re, last_re);
    chk("do_im", do_im, last_im);
    chk("do_idx", do_idx, last_idx);
    chk("di_ready", di_ready, drain_left == 0);
    chk("busy", busy, drain_left > 0 || p >= D || pend_re.size() > 0);
    if (do_en) begin
      obs_re.push_back(int'($signed(do_re)));
      obs_idx.push_back(int'(do_idx));
    end
    if (!di_ready) ready_low++;
  endtask

  task automatic apply_reset(input logic check_now);
    #2 reset = 1'b1;
    di_en = 1'b0;
    flush = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_now_do_en", do_en, 0);
      chk("rst_now_do_re", do_re, 0);
      chk("rst_now_do_im", do_im, 0);
      chk("rst_now_do_idx", do_idx, 0);
      chk("rst_now_ready", di_ready, 1);
      chk("rst_now_busy", busy, 0);
    end
    @(posedge clock);
    #1;
    chk("rst_do_en", do_en, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_idx", do_idx, 0);
    chk("rst_ready", di_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_log(input string tag, input int exp_re[8], input int exp_ready_low);
    chk({tag, "_count"}, obs_re.size(), 8);
    chk({tag, "_ready_low"}, ready_low, exp_ready_low);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_re.size()) begin
        chk({tag, "_re"}, obs_re[i], exp_re[i]);
        chk({tag, "_idx"}, obs_idx[i], i);
      end
    end
  endtask

  task automatic flush_drain();
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < D; i++) step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic basic_frame();
    for (int i = 0; i < 8; i++) step(1'b1, i, 0, 1'b0);
    flush_drain();
  endtask

  function automatic int rnd();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  initial begin
    reset = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    flush = 1'b0;
    model_clear();
    apply_reset(1'b0);

    // basic frame with drain
    log_clear();
    basic_frame();
    check_log("basic", basic_re, 4);

    // scaling extremes: first half x0, second half x1
    log_clear();
    step(1'b1, 32767, rnd(), 1'b0);
    step(1'b1, 32767, rnd(), 1'b0);
    step(1'b1, -32768, rnd(), 1'b0);
    step(1'b1, 0, -32768, 1'b0);
    step(1'b1, 32767, rnd(), 1'b0);
    step(1'b1, -32768, rnd(), 1'b0);
    step(1'b1, 32767, rnd(), 1'b0);
    step(1'b1, -1, 32767, 1'b0);
    flush_drain();
    check_log("extreme", ext_re, 4);

    // continuous streaming, three frames, then drain
    log_clear();
    for (int i = 0; i < 24; i++) step(1'b1, rnd(), rnd(), 1'b0);
    flush_drain();
    chk("stream_count", obs_re.size(), 24);
    chk("stream_ready_low", ready_low, 4);

    // gapped input, same data as basic frame
    log_clear();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i, 0, 1'b0);
      for (int g = 0; g < int'($urandom_range(1, 2)); g++) step(1'b0, rnd(), rnd(), 1'b0);
    end
    flush_drain();
    check_log("gapped", basic_re, 4);

    // flush corner cases
    log_clear();
    for (int i = 0; i < 8; i++) step(1'b1, rnd(), rnd(), 1'b1);
    step(1'b1, rnd(), rnd(), 1'b1);
    step(1'b1, rnd(), rnd(), 1'b0);
    step(1'b0, rnd(), rnd(), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, rnd(), rnd(), 1'b0);
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < D + 1; i++) step(1'b1, rnd(), rnd(), 1'b0);
    chk("corner_ready_low", ready_low, 4);

    // reset mid-BFLY, then clean frame
    for (int i = 0; i < 6; i++) step(1'b1, rnd(), rnd(), 1'b0);
    apply_reset(1'b1);
    log_clear();
    basic_frame();
    check_log("after_rst_bfly", basic_re, 4);

    // reset mid-DRAIN, then clean frame
    for (int i = 0; i < 8; i++) step(1'b1, rnd(), rnd(), 1'b0);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, rnd(), rnd(), 1'b0);
    apply_reset(1'b1);
    log_clear();
    basic_frame();
    check_log("after_rst_drain", basic_re, 4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, rnd(), rnd(), $urandom_range(3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
